// File: rtl/arb_rr_oht_if.sv
// Request/grant bundle between requesters, the round-robin arbiter and the downstream sink.
// The master modport is the arbiter view and the slave modport is the requester/sink view.
interface arb_rr_oht_if #(
    parameter int WIDTH = 4
);
    localparam int WIDTH_LOG = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]     req;
    logic                 ack;
    logic                 lst;
    logic [WIDTH-1:0]     grt;
    logic [WIDTH_LOG-1:0] idx;
    logic                 vld;
    logic                 lck;

    modport master (
        input  req, ack, lst,
        output grt, idx, vld, lck
    );

    modport slave (
        output req, ack, lst,
        input  grt, idx, vld, lck
    );
endinterface

// File: rtl/arb_rr_oht.sv
// Round-robin arbiter with one-hot grant that locks onto a requester until the
// last beat of its packet is accepted.
module arb_rr_oht #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    arb_rr_oht_if.master bus
);
    localparam int WIDTH_LOG = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [WIDTH_LOG-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]     gnt_q, gnt_d;

    logic [WIDTH-1:0]     hi_mask;
    logic [WIDTH-1:0]     req_hi;
    logic [WIDTH-1:0]     arb_gnt;
    logic [WIDTH-1:0]     grt;
    logic [WIDTH_LOG-1:0] idx;
    logic                 vld;
    logic                 done;

    // Two-level search: lowest request at or above ptr, else lowest overall (wrap).
    // x & (~x + 1) isolates the lowest set bit, so the result is one-hot by construction.
    always_comb begin
        hi_mask = ~((WIDTH'(1) << ptr_q) - WIDTH'(1));
        req_hi  = bus.req & hi_mask;
        if (req_hi != '0) begin
            arb_gnt = req_hi & (~req_hi + WIDTH'(1));
        end else begin
            arb_gnt = bus.req & (~bus.req + WIDTH'(1));
        end
    end

    assign grt  = (state_q == ST_LOCK) ? gnt_q : arb_gnt;
    assign vld  = |(bus.req & grt);
    assign done = vld && bus.ack && bus.lst;

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (grt[i]) begin
                idx = idx | WIDTH_LOG'(i);
            end
        end
    end

    // NOTE: every variable gets its hold value before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        if (done) begin
            state_d = ST_IDLE;
            ptr_d   = (idx == WIDTH_LOG'(WIDTH - 1)) ? '0 : idx + WIDTH_LOG'(1);
        end else if (state_q == ST_IDLE && vld) begin
            state_d = ST_LOCK;
            gnt_d   = grt;
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update from the
    // same pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    assign bus.grt = grt;
    assign bus.idx = idx;
    assign bus.vld = vld;
    assign bus.lck = (state_q == ST_LOCK);
endmodule

// File: tb/tb_arb_rr_oht.sv
// Directed bench for arb_rr_oht (WIDTH = 4): expected outputs are queued as each
// step is driven and popped when the outputs are sampled, mid-cycle.
module tb_arb_rr_oht;
    typedef struct {
        string      tag;
        logic [3:0] grt;
        logic [1:0] idx;
        logic       vld;
        logic       lck;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    arb_rr_oht_if #(.WIDTH(4)) bus ();

    arb_rr_oht #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge, queue the expected outputs,
    // sample once the combinational path has settled, then advance to the next cycle.
    task automatic step(input string tag, input logic r, input logic [3:0] rq,
                        input logic a, input logic l,
                        input logic [3:0] eg, input logic [1:0] ei,
                        input logic ev, input logic el);
        exp_t e;
        rst     = r;
        bus.req = rq;
        bus.ack = a;
        bus.lst = l;
        e.tag = tag; e.grt = eg; e.idx = ei; e.vld = ev; e.lck = el;
        sb_q.push_back(e);
        #2;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, ".grt"}, 32'(bus.grt), 32'(e.grt));
            check({e.tag, ".idx"}, 32'(bus.idx), 32'(e.idx));
            check({e.tag, ".vld"}, 32'(bus.vld), 32'(e.vld));
            check({e.tag, ".lck"}, 32'(bus.lck), 32'(e.lck));
            check({e.tag, ".onehot"}, 32'($countones(bus.grt) <= 1), 32'(1));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req = '0;
        bus.ack = 1'b0;
        bus.lst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: idle function of req with req == 0.
        step("reset_idle", 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Rotation with single-beat packets; ptr goes 0 -> 2 -> 0 (wrap) -> 2.
        step("rot0", 1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
        step("rot1", 1'b0, 4'b1010, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
        step("rot2", 1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);

        // Idle cycles: ack/lst ignored, ptr stays 2.
        for (int i = 0; i < 5; i++) begin
            step($sformatf("idle%0d", i), 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        step("idle_ptr_kept", 1'b0, 4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
        step("idle_same_cyc", 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
        step("ptr_to_zero", 1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);

        // Packet lock on requester 0 for three non-last beats, then the last beat.
        step("lock_c1", 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step("lock_c2", 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1);
        step("lock_c3", 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1);
        step("lock_last", 1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1);
        step("lock_next", 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);

        // Locked on 0010, requester drops: vld low, lock held, ack/lst ignored.
        step("drop_c1", 1'b0, 4'b0001, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1);
        step("drop_c2", 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1);
        step("drop_done", 1'b0, 4'b0011, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1);

        // Backpressure on requester 2; after completion ptr = 3 wraps to requester 0.
        step("bp_grant", 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step("bp_hold", 1'b0, 4'b0101, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1);
        step("bp_beat", 1'b0, 4'b0101, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1);
        step("bp_last", 1'b0, 4'b0101, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1);
        step("bp_wrap", 1'b0, 4'b0101, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step("bp_close", 1'b0, 4'b0101, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1);

        // Reset in the middle of a packet locked on 1000 with ptr = 2.
        step("rl_ptr2", 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
        step("rl_grant", 1'b0, 4'b1000, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        step("rl_locked", 1'b0, 4'b1111, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1);
        step("rl_rst", 1'b1, 4'b1111, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1);
        step("rl_after", 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step("rl_close", 1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1);
        step("rl_rearb", 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_drain: observed=%0d expected=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
